// File: rtl/complex_multiplier_axis_pkg.sv
// Shared types and the scale/saturate helper for the complex multiplier.
package complex_multiplier_axis_pkg;

  // Wide enough for any full-precision product component this block will see.
  localparam int MAX_W = 72;

  typedef logic signed [MAX_W-1:0] wide_t;

  // Arithmetic right shift (floor) then clamp to a signed outw-bit range.
  function automatic wide_t shift_sat(input wide_t v, input int sh, input int outw);
    wide_t s;
    wide_t hi;
    wide_t lo;
    s  = v >>> sh;
    hi = (wide_t'(1) <<< (outw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (outw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/complex_multiplier_axis_pipe_delay.sv
// Register delay line of parametric width/depth; each data stage loads only
// when the valid travelling beside it is set, so data holds across gaps.
module complex_multiplier_axis_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             vld_o
);

  // Index 0 is the input tap; index k is the output of register stage k.
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;

  assign vld_pipe[0] = vld_i;
  assign dat_pipe[0] = din_i;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stg
    logic             vld_q;
    logic [WIDTH-1:0] dat_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_q <= dat_pipe[k-1];
      end
    end

    assign vld_pipe[k] = vld_q;
    assign dat_pipe[k] = dat_q;
  end

  assign dout_o = dat_pipe[DEPTH];
  assign vld_o  = vld_pipe[DEPTH];

endmodule

// File: rtl/complex_multiplier_axis.sv
// Pipelined signed complex multiplier, valid-only streaming in/out, with
// arithmetic-shift scaling and per-component saturation.
module complex_multiplier_axis
  import complex_multiplier_axis_pkg::*;
#(
  parameter int OPERAND_WIDTH_A   = 16,
  parameter int OPERAND_WIDTH_B   = 16,
  parameter int OPERAND_WIDTH_OUT = 16,
  parameter int STAGES            = 6,
  parameter int BLOCKING          = 0,
  parameter int GROWTH_BITS       = 0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [2*OPERAND_WIDTH_A-1:0]   s_axis_a_tdata,
  input  logic                           s_axis_a_tvalid,
  input  logic [2*OPERAND_WIDTH_B-1:0]   s_axis_b_tdata,
  input  logic                           s_axis_b_tvalid,
  output logic [2*OPERAND_WIDTH_OUT-1:0] m_axis_dout_tdata,
  output logic                           m_axis_dout_tvalid
);

  localparam int WA   = OPERAND_WIDTH_A;
  localparam int WB   = OPERAND_WIDTH_B;
  localparam int WO   = OPERAND_WIDTH_OUT;
  localparam int PW   = WA + WB;
  localparam int WP   = WA + WB + 1;
  localparam int SH   = WA + WB - WO + 1 + GROWTH_BITS;
  localparam int TAIL = STAGES - 3;

  if (BLOCKING != 0) begin : g_err_blocking
    $error("complex_multiplier_axis: only BLOCKING=0 is supported");
  end
  if (STAGES < 3) begin : g_err_stages
    $error("complex_multiplier_axis: STAGES must be >= 3");
  end
  if (SH < 0) begin : g_err_shift
    $error("complex_multiplier_axis: output shift is negative");
  end
  if (WP > MAX_W) begin : g_err_width
    $error("complex_multiplier_axis: operands too wide for shift_sat");
  end

  logic fire;
  assign fire = s_axis_a_tvalid & s_axis_b_tvalid;

  // vld_q[n] is the valid beside the stage-n registers.
  logic [3:1] vld_q;

  // Stage 1: operand registers
  logic signed [WA-1:0] ar_q, ai_q;
  logic signed [WB-1:0] br_q, bi_q;

  // Stage 2: partial products
  logic signed [PW-1:0] pp_rr_d, pp_ii_d, pp_ri_d, pp_ir_d;
  logic signed [PW-1:0] pp_rr_q, pp_ii_q, pp_ri_q, pp_ir_q;

  // Stage 3: scaled and saturated result
  logic signed [WP-1:0] re_full, im_full;
  logic        [WO-1:0] re_d, im_d, re_q, im_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[2:1], fire};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_q <= '0;
      ai_q <= '0;
      br_q <= '0;
      bi_q <= '0;
    end else if (fire) begin
      ar_q <= s_axis_a_tdata[WA-1:0];
      ai_q <= s_axis_a_tdata[2*WA-1:WA];
      br_q <= s_axis_b_tdata[WB-1:0];
      bi_q <= s_axis_b_tdata[2*WB-1:WB];
    end
  end

  // Operands sign-extended to the product width so the multiply is exact.
  assign pp_rr_d = PW'(ar_q) * PW'(br_q);
  assign pp_ii_d = PW'(ai_q) * PW'(bi_q);
  assign pp_ri_d = PW'(ar_q) * PW'(bi_q);
  assign pp_ir_d = PW'(ai_q) * PW'(br_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pp_rr_q <= '0;
      pp_ii_q <= '0;
      pp_ri_q <= '0;
      pp_ir_q <= '0;
    end else if (vld_q[1]) begin
      pp_rr_q <= pp_rr_d;
      pp_ii_q <= pp_ii_d;
      pp_ri_q <= pp_ri_d;
      pp_ir_q <= pp_ir_d;
    end
  end

  // One guard bit absorbs the (-2^(W-1))^2 + (-2^(W-1))^2 corner.
  assign re_full = WP'(pp_rr_q) - WP'(pp_ii_q);
  assign im_full = WP'(pp_ri_q) + WP'(pp_ir_q);
  assign re_d    = WO'(shift_sat(wide_t'(re_full), SH, WO));
  assign im_d    = WO'(shift_sat(wide_t'(im_full), SH, WO));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      re_q <= '0;
      im_q <= '0;
    end else if (vld_q[2]) begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  complex_multiplier_axis_pipe_delay #(
    .WIDTH (2*WO),
    .DEPTH (TAIL)
  ) u_tail (
    .clk_i   (aclk),
    .rst_n_i (aresetn),
    .din_i   ({im_q, re_q}),
    .vld_i   (vld_q[3]),
    .dout_o  (m_axis_dout_tdata),
    .vld_o   (m_axis_dout_tvalid)
  );

endmodule

// File: tb/tb_complex_multiplier_axis.sv
// Scoreboard bench: the driver queues hand-computed results with their due
// cycle; a negedge monitor pops and compares whenever tvalid is seen.
`timescale 1ns/1ps
module tb_complex_multiplier_axis;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axis_a_tdata = '0;
  logic        s_axis_a_tvalid = 1'b0;
  logic [31:0] s_axis_b_tdata = '0;
  logic        s_axis_b_tvalid = 1'b0;
  logic [31:0] m_axis_dout_tdata;
  logic        m_axis_dout_tvalid;

  complex_multiplier_axis #(
    .OPERAND_WIDTH_A   (16),
    .OPERAND_WIDTH_B   (16),
    .OPERAND_WIDTH_OUT (16),
    .STAGES            (6),
    .BLOCKING          (0),
    .GROWTH_BITS       (-2)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_a_tdata     (s_axis_a_tdata),
    .s_axis_a_tvalid    (s_axis_a_tvalid),
    .s_axis_b_tdata     (s_axis_b_tdata),
    .s_axis_b_tvalid    (s_axis_b_tvalid),
    .m_axis_dout_tdata  (m_axis_dout_tdata),
    .m_axis_dout_tvalid (m_axis_dout_tvalid)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_exp = '0;

  always @(posedge aclk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
  endfunction

  // Monitor: latency, data, exactly-once delivery and hold-during-gap.
  always @(negedge aclk) begin
    if (aresetn && mon_en) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_chk++;
        $display("FAIL missing_result: due cyc %0d, now %0d, want %h", sb[0].due, cyc, sb[0].data);
        void'(sb.pop_front());
      end
      if (m_axis_dout_tvalid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid @cyc %0d: data %h, want no valid", cyc, m_axis_dout_tdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dout_cycle", 32'(cyc), 32'(e.due));
          chk("dout_data", m_axis_dout_tdata, e.data);
          last_exp = e.data;
        end
      end else begin
        chk("hold_data", m_axis_dout_tdata, last_exp);
      end
    end
  end

  task automatic drive(input bit av, input bit bv, input int ar, input int ai,
                       input int br, input int bi, input int er, input int ei);
    @(negedge aclk);
    s_axis_a_tvalid = av;
    s_axis_b_tvalid = bv;
    s_axis_a_tdata  = {16'(ai), 16'(ar)};
    s_axis_b_tdata  = {16'(bi), 16'(br)};
    if (av && bv) sb.push_back('{data: {16'(ei), 16'(er)}, due: cyc + 6});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  int g_ar[8] = '{301, -301, 5, -1, 0, 20000, -32767, 7};
  int g_er[8] = '{150, -151, 2, -1, 0, 10000, -16384, 3};
  int g_ei[8] = '{-151, 150, -3, 0, 0, -10000, 16383, -4};

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("reset_tvalid", 32'(m_axis_dout_tvalid), 32'd0);
      chk("reset_tdata", m_axis_dout_tdata, 32'd0);
    end
    aresetn = 1'b1;
    mon_en  = 1'b1;
    idle(2);

    // Single fire, then floor and mixed cases, then saturation corner
    drive(1, 1, 1000, 0, 32767, 0, 999, 0);
    idle(8);
    drive(1, 1, 0, 1000, 0, 32767, -1000, 0);
    drive(1, 1, 1000, 2000, 16384, 16384, -500, 1500);
    drive(1, 1, -32768, -32768, -32768, 32767, 32767, 1);
    idle(8);

    // Lone operands are discarded
    for (int i = 0; i < 10; i++) drive(1, 0, 12345 + i, -222, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 777, 31000, 0, 0);
    idle(8);

    // Back-to-back ramp
    for (int k = 0; k < 256; k++) drive(1, 1, k, 0, 32767, 0, (k == 0) ? 0 : k - 1, 0);
    idle(8);

    // Alternating gaps; junk on A during gaps must not disturb held data
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, g_ar[i], -g_ar[i], 16384, 0, g_er[i], g_ei[i]);
      drive(1, 0, 999, 999, 0, 0, 0, 0);
    end
    idle(8);

    // Reset with five results in flight, the first one already on the output
    for (int k = 1; k <= 5; k++) drive(1, 1, k, 0, 32767, 0, k - 1, 0);
    idle(1);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(m_axis_dout_tvalid), 32'd0);
    chk("async_rst_tdata", m_axis_dout_tdata, 32'd0);
    sb.delete();
    last_exp = '0;
    idle(2);

    // Fire presented so it lands on the first edge after release
    drive(1, 1, -1000, 0, 32767, 0, -1000, 0);
    #1;
    aresetn = 1'b1;
    idle(10);

    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
